pipe_ctrl: RTL and testbench

Pipeline flow controller: the consumer of the hazard detector's `doStall`/`doFwd` requests. Combines them with branch redirects, memory wait and halt requests into per-stage enables, bubble and flush controls for the 5-stage core. Registers the EX-stage forwarding select, runs the halt/drain state machine and keeps saturating stall/flush counters for debug readout.

---
 rtl/pipe_ctrl_pkg.sv | 28 ++
 rtl/pipe_ctrl_if.sv | 36 +++
 rtl/pipe_ctrl_sat_counter.sv | 20 ++
 rtl/pipe_ctrl.sv | 118 +++++++++++
 tb/tb_pipe_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline flow controller: state encodings,
// default parameters and the control-bundle layout used for debug readout.
package pipe_ctrl_pkg;

    localparam int CNT_W_DEF        = 16;
    localparam int DRAIN_CYCLES_DEF = 3;
    localparam int DRAIN_W          = 3;

    typedef enum logic [1:0] {
        PC_RUN   = 2'd0,
        PC_DRAIN = 2'd1,
        PC_HALT  = 2'd2
    } pc_state_e;

    typedef struct packed {
        logic enPC;
        logic enIFID;
        logic enIDEX;
        logic bubbleIDEX;
        logic flushIFID;
        logic enLate;
    } pc_ctrl_t;

    function automatic logic [DRAIN_W-1:0] drainLoad(input int cycles);
        return DRAIN_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/control bundle between the core datapath (master) and pipe_ctrl (slave).
// Requests are level signals sampled every cycle; the controls answer them
// combinationally in the same cycle, while fwdEX, halted and counters are registered.
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             doStall;
    logic             doFwd;
    logic             brTaken;
    logic             memBusy;
    logic             haltReq;
    logic             resume;
    logic             cntClr;
    logic             enPC;
    logic             enIFID;
    logic             enIDEX;
    logic             bubbleIDEX;
    logic             flushIFID;
    logic             enLate;
    logic             fwdEX;
    logic             halted;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    modport master (
        output doStall, doFwd, brTaken, memBusy, haltReq, resume, cntClr,
        input  enPC, enIFID, enIDEX, bubbleIDEX, flushIFID, enLate,
               fwdEX, halted, stallCnt, flushCnt
    );

    modport slave (
        input  doStall, doFwd, brTaken, memBusy, haltReq, resume, cntClr,
        output enPC, enIFID, enIDEX, bubbleIDEX, flushIFID, enLate,
               fwdEX, halted, stallCnt, flushCnt
    );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline flow controller: turns hazard, branch, memory-wait and halt requests
// into per-stage enables/bubble/flush, and runs the halt/drain state machine.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    pipe_ctrl_if.slave    bus,
    output pc_state_e     dbgState
);
    pc_state_e          state, nextState;
    pc_ctrl_t           ctrl;
    logic [DRAIN_W-1:0] drainCnt;
    logic               drainLd, drainDec;
    logic               stallInc, flushInc;

    always_comb begin
        ctrl      = '0;
        nextState = state;
        drainLd   = 1'b0;
        drainDec  = 1'b0;
        stallInc  = 1'b0;
        flushInc  = 1'b0;
        case (state)
            PC_RUN: begin
                if (bus.memBusy) begin
                    stallInc = 1'b1;
                end else if (bus.brTaken) begin
                    ctrl     = '{enPC: 1'b1, enIFID: 1'b1, enIDEX: 1'b1,
                                 bubbleIDEX: 1'b1, flushIFID: 1'b1, enLate: 1'b1};
                    flushInc = 1'b1;
                end else if (bus.doStall) begin
                    ctrl     = '{enPC: 1'b0, enIFID: 1'b0, enIDEX: 1'b1,
                                 bubbleIDEX: 1'b1, flushIFID: 1'b0, enLate: 1'b1};
                    stallInc = 1'b1;
                end else if (bus.haltReq) begin
                    // Halt instruction itself advances into ID/EX as a bubble.
                    ctrl      = '{enPC: 1'b1, enIFID: 1'b1, enIDEX: 1'b1,
                                  bubbleIDEX: 1'b1, flushIFID: 1'b0, enLate: 1'b1};
                    nextState = PC_DRAIN;
                    drainLd   = 1'b1;
                end else begin
                    ctrl = '{enPC: 1'b1, enIFID: 1'b1, enIDEX: 1'b1,
                             bubbleIDEX: 1'b0, flushIFID: 1'b0, enLate: 1'b1};
                end
            end
            PC_DRAIN: begin
                ctrl.enIDEX     = 1'b1;
                ctrl.bubbleIDEX = 1'b1;
                ctrl.enLate     = ~bus.memBusy;
                stallInc        = bus.memBusy;
                // An older branch resolving in EX still redirects the PC.
                if (bus.brTaken && !bus.memBusy) begin
                    ctrl.enPC = 1'b1;
                    flushInc  = 1'b1;
                end
                if (!bus.memBusy) begin
                    if (drainCnt == '0) nextState = PC_HALT;
                    else                drainDec  = 1'b1;
                end
            end
            PC_HALT: begin
                if (bus.resume) nextState = PC_RUN;
            end
            default: nextState = PC_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= PC_RUN;
            drainCnt <= '0;
        end else begin
            state <= nextState;
            if (drainLd)       drainCnt <= drainLoad(DRAIN_CYCLES);
            else if (drainDec) drainCnt <= drainCnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.fwdEX  <= 1'b0;
            bus.halted <= 1'b0;
        end else begin
            bus.halted <= (state == PC_HALT);
            if (state != PC_RUN)  bus.fwdEX <= 1'b0;
            else if (ctrl.enIDEX) bus.fwdEX <= bus.doFwd & ~ctrl.bubbleIDEX;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) uStallCnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (stallInc),
        .clr  (bus.cntClr),
        .cnt  (bus.stallCnt)
    );

    sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (flushInc),
        .clr  (bus.cntClr),
        .cnt  (bus.flushCnt)
    );

    assign bus.enPC       = ctrl.enPC;
    assign bus.enIFID     = ctrl.enIFID;
    assign bus.enIDEX     = ctrl.enIDEX;
    assign bus.bubbleIDEX = ctrl.bubbleIDEX;
    assign bus.flushIFID  = ctrl.flushIFID;
    assign bus.enLate     = ctrl.enLate;
    assign dbgState       = state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with 4-bit counters and a 3-cycle drain.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int CNT_W = 4;

    logic      clk;
    logic      rstn;
    pc_state_e dbgState;
    int        vecs = 0;
    int        miss = 0;

    pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(3)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus),
        .dbgState (dbgState)
    );

    // {enPC, enIFID, enIDEX, bubbleIDEX, flushIFID, enLate}
    logic [5:0] ctl;
    assign ctl = {bus.enPC, bus.enIFID, bus.enIDEX, bus.bubbleIDEX, bus.flushIFID, bus.enLate};

    localparam logic [5:0] CTL_RUN   = 6'b111001;
    localparam logic [5:0] CTL_STALL = 6'b001101;
    localparam logic [5:0] CTL_BR    = 6'b111111;
    localparam logic [5:0] CTL_HREQ  = 6'b111101;
    localparam logic [5:0] CTL_DRBSY = 6'b001100;
    localparam logic [5:0] CTL_DRAIN = 6'b001101;
    localparam logic [5:0] CTL_OFF   = 6'b000000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.doStall = 0; bus.doFwd = 0; bus.brTaken = 0; bus.memBusy = 0;
        bus.haltReq = 0; bus.resume = 0; bus.cntClr = 0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle();
        #12;
        vecs++; if (dbgState !== PC_RUN) begin miss++; $display("FAIL reset_state: got %0d expected %0d", dbgState, PC_RUN); end
        vecs++; if (ctl !== CTL_RUN) begin miss++; $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_RUN); end
        vecs++; if (bus.halted !== 1'b0) begin miss++; $display("FAIL reset_halted: got %b expected 0", bus.halted); end
        vecs++; if (bus.fwdEX !== 1'b0) begin miss++; $display("FAIL reset_fwd: got %b expected 0", bus.fwdEX); end
        vecs++; if ({bus.stallCnt, bus.flushCnt} !== 8'h00) begin miss++; $display("FAIL reset_cnt: got %h expected 00", {bus.stallCnt, bus.flushCnt}); end
        @(negedge clk);
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_stall();
        bus.doStall = 1;
        #1;
        for (int i = 1; i <= 2; i++) begin
            vecs++; if (ctl !== CTL_STALL) begin miss++; $display("FAIL stall_ctl%0d: got %b expected %b", i, ctl, CTL_STALL); end
            tick();
            vecs++; if (bus.stallCnt !== 4'(i)) begin miss++; $display("FAIL stall_cnt%0d: got %0d expected %0d", i, bus.stallCnt, i); end
            vecs++; if (bus.fwdEX !== 1'b0) begin miss++; $display("FAIL stall_fwd%0d: got %b expected 0", i, bus.fwdEX); end
        end
        bus.doStall = 0;
    endtask

    task automatic test_fwd_freeze();
        bus.cntClr = 1;
        tick();
        bus.cntClr = 0;
        vecs++; if (bus.stallCnt !== 4'd0) begin miss++; $display("FAIL fwd_clr: got %0d expected 0", bus.stallCnt); end
        bus.doFwd = 1;
        #1;
        vecs++; if (ctl !== CTL_RUN) begin miss++; $display("FAIL fwd_ctl: got %b expected %b", ctl, CTL_RUN); end
        tick();
        bus.doFwd = 0;
        bus.memBusy = 1;
        #1;
        vecs++; if (bus.fwdEX !== 1'b1) begin miss++; $display("FAIL fwd_load: got %b expected 1", bus.fwdEX); end
        for (int i = 0; i < 3; i++) begin
            vecs++; if (ctl !== CTL_OFF) begin miss++; $display("FAIL freeze_ctl%0d: got %b expected %b", i, ctl, CTL_OFF); end
            tick();
            vecs++; if (bus.fwdEX !== 1'b1) begin miss++; $display("FAIL freeze_fwd%0d: got %b expected 1", i, bus.fwdEX); end
        end
        vecs++; if (bus.stallCnt !== 4'd3) begin miss++; $display("FAIL freeze_cnt: got %0d expected 3", bus.stallCnt); end
        bus.memBusy = 0;
    endtask

    task automatic test_branch_stall();
        bus.cntClr = 1;
        tick();
        bus.cntClr = 0;
        bus.brTaken = 1;
        bus.doStall = 1;
        #1;
        vecs++; if (ctl !== CTL_BR) begin miss++; $display("FAIL br_ctl: got %b expected %b", ctl, CTL_BR); end
        tick();
        idle();
        vecs++; if (bus.flushCnt !== 4'd1) begin miss++; $display("FAIL br_flushcnt: got %0d expected 1", bus.flushCnt); end
        vecs++; if (bus.stallCnt !== 4'd0) begin miss++; $display("FAIL br_stallcnt: got %0d expected 0", bus.stallCnt); end
        vecs++; if (bus.fwdEX !== 1'b0) begin miss++; $display("FAIL br_fwd: got %b expected 0", bus.fwdEX); end
    endtask

    task automatic test_halt();
        int n;
        bus.haltReq = 1;
        #1;
        vecs++; if (ctl !== CTL_HREQ) begin miss++; $display("FAIL halt_req_ctl: got %b expected %b", ctl, CTL_HREQ); end
        tick();
        bus.haltReq = 0;
        bus.memBusy = 1;
        #1;
        vecs++; if (dbgState !== PC_DRAIN) begin miss++; $display("FAIL halt_drain: got %0d expected %0d", dbgState, PC_DRAIN); end
        vecs++; if (ctl !== CTL_DRBSY) begin miss++; $display("FAIL drain_busy_ctl: got %b expected %b", ctl, CTL_DRBSY); end
        tick();
        bus.memBusy = 0;
        #1;
        vecs++; if (ctl !== CTL_DRAIN) begin miss++; $display("FAIL drain_ctl: got %b expected %b", ctl, CTL_DRAIN); end
        n = 2;
        while (bus.halted !== 1'b1 && n < 20) begin
            tick();
            if (bus.halted !== 1'b1) n++;
        end
        vecs++; if (n !== 5) begin miss++; $display("FAIL halt_latency: got %0d edges expected 5", n); end
        vecs++; if (ctl !== CTL_OFF) begin miss++; $display("FAIL halted_ctl: got %b expected %b", ctl, CTL_OFF); end
        bus.resume = 1;
        tick();
        bus.resume = 0;
        #1;
        vecs++; if (dbgState !== PC_RUN) begin miss++; $display("FAIL resume_state: got %0d expected %0d", dbgState, PC_RUN); end
        vecs++; if (ctl !== CTL_RUN) begin miss++; $display("FAIL resume_ctl: got %b expected %b", ctl, CTL_RUN); end
        tick();
        vecs++; if (bus.halted !== 1'b0) begin miss++; $display("FAIL resume_halted: got %b expected 0", bus.halted); end
    endtask

    task automatic test_saturate();
        bus.cntClr = 1;
        tick();
        bus.cntClr = 0;
        bus.doStall = 1;
        for (int i = 0; i < 15; i++) tick();
        vecs++; if (bus.stallCnt !== 4'd15) begin miss++; $display("FAIL sat_15: got %0d expected 15", bus.stallCnt); end
        for (int i = 0; i < 5; i++) tick();
        vecs++; if (bus.stallCnt !== 4'd15) begin miss++; $display("FAIL sat_20: got %0d expected 15", bus.stallCnt); end
        bus.cntClr = 1;
        tick();
        bus.cntClr = 0;
        bus.doStall = 0;
        vecs++; if (bus.stallCnt !== 4'd0) begin miss++; $display("FAIL sat_clr: got %0d expected 0", bus.stallCnt); end
    endtask

    task automatic test_reset_mid_drain();
        bus.doStall = 1;
        tick();
        bus.doStall = 0;
        bus.brTaken = 1;
        tick();
        bus.brTaken = 0;
        bus.haltReq = 1;
        tick();
        bus.haltReq = 0;
        tick();
        vecs++; if (dbgState !== PC_DRAIN) begin miss++; $display("FAIL mid_drain: got %0d expected %0d", dbgState, PC_DRAIN); end
        #2;
        rstn = 1'b0;
        #1;
        vecs++; if (dbgState !== PC_RUN) begin miss++; $display("FAIL arst_state: got %0d expected %0d", dbgState, PC_RUN); end
        vecs++; if ({bus.halted, bus.fwdEX} !== 2'b00) begin miss++; $display("FAIL arst_flags: got %b expected 00", {bus.halted, bus.fwdEX}); end
        vecs++; if ({bus.stallCnt, bus.flushCnt} !== 8'h00) begin miss++; $display("FAIL arst_cnt: got %h expected 00", {bus.stallCnt, bus.flushCnt}); end
        vecs++; if (ctl !== CTL_RUN) begin miss++; $display("FAIL arst_ctl: got %b expected %b", ctl, CTL_RUN); end
        @(negedge clk);
        rstn = 1'b1;
        bus.doFwd = 1;
        tick();
        bus.doFwd = 0;
        vecs++; if (bus.fwdEX !== 1'b1) begin miss++; $display("FAIL post_rst_fwd: got %b expected 1", bus.fwdEX); end
        vecs++; if (dbgState !== PC_RUN) begin miss++; $display("FAIL post_rst_state: got %0d expected %0d", dbgState, PC_RUN); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_fwd_freeze();
        test_branch_stall();
        test_halt();
        test_saturate();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
